// File: rtl/l1a_evt_queue_if.sv
// rtl/l1a_evt_queue_if.sv - decision inputs, readout handshake and status of the L1A event queue
interface l1a_evt_queue_if #(
  parameter int DEPTH_LOG2 = 3,
  parameter int EVTNUM_W   = 12
);
  logic                  MATCHR;
  logic                  NO_MATCH;
  logic                  EVTNUM_RST;
  logic                  POP;
  logic                  EVT_VALID;
  logic                  EVT_MATCH;
  logic [EVTNUM_W-1:0]   EVT_NUM;
  logic [DEPTH_LOG2:0]   DEPTH;
  logic                  FULL;
  logic                  OVFL;
  logic                  PROTO_ERR;

  modport master (
    output MATCHR, NO_MATCH, EVTNUM_RST, POP,
    input  EVT_VALID, EVT_MATCH, EVT_NUM, DEPTH, FULL, OVFL, PROTO_ERR
  );

  modport slave (
    input  MATCHR, NO_MATCH, EVTNUM_RST, POP,
    output EVT_VALID, EVT_MATCH, EVT_NUM, DEPTH, FULL, OVFL, PROTO_ERR
  );
endinterface

// File: rtl/l1a_evt_queue.sv
// rtl/l1a_evt_queue.sv - event-numbered FWFT queue of trigger match decisions
module l1a_evt_queue #(
  parameter int DEPTH_LOG2 = 3,
  parameter int EVTNUM_W   = 12
) (
  input  logic              CLK,
  input  logic              RST,
  l1a_evt_queue_if.slave    bus
);
  localparam int N = 1 << DEPTH_LOG2;

  logic [EVTNUM_W:0]     mem [N];
  logic [DEPTH_LOG2:0]   wptr, rptr;
  logic [DEPTH_LOG2:0]   wptr_next, rptr_next;
  logic [DEPTH_LOG2:0]   count, count_after_pop, depth_next;
  logic [EVTNUM_W-1:0]   evtcnt, tag;
  logic                  decision, pop_fire, push_ok, head_avail;
  logic                  out_valid, out_match, full_q, ovfl_q, proto_q;
  logic [EVTNUM_W-1:0]   out_num;
  logic [DEPTH_LOG2:0]   depth_q;
  logic [EVTNUM_W:0]     head_entry;

  always_comb begin
    decision        = bus.MATCHR | bus.NO_MATCH;
    pop_fire        = bus.POP & out_valid;
    // a full queue still accepts a push when the head leaves in the same cycle
    push_ok         = decision & (~full_q | pop_fire);
    tag             = bus.EVTNUM_RST ? '0 : evtcnt;
    count           = wptr - rptr;
    count_after_pop = count - {{DEPTH_LOG2{1'b0}}, pop_fire};
    rptr_next       = rptr + {{DEPTH_LOG2{1'b0}}, pop_fire};
    wptr_next       = wptr + {{DEPTH_LOG2{1'b0}}, push_ok};
    depth_next      = wptr_next - rptr_next;
    // the head register only sees entries stored before this edge
    head_avail      = count_after_pop != '0;
    head_entry      = mem[rptr_next[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge CLK) begin
    if (!RST && push_ok) begin
      mem[wptr[DEPTH_LOG2-1:0]] <= {bus.MATCHR, tag};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr      <= '0;
      rptr      <= '0;
      depth_q   <= '0;
      full_q    <= 1'b0;
      evtcnt    <= '0;
      ovfl_q    <= 1'b0;
      proto_q   <= 1'b0;
      out_valid <= 1'b0;
      out_match <= 1'b0;
      out_num   <= '0;
    end else begin
      wptr      <= wptr_next;
      rptr      <= rptr_next;
      depth_q   <= depth_next;
      full_q    <= depth_next == (DEPTH_LOG2+1)'(N);
      if (bus.EVTNUM_RST) begin
        evtcnt <= {{(EVTNUM_W-1){1'b0}}, decision};
      end else if (decision) begin
        evtcnt <= evtcnt + EVTNUM_W'(1);
      end
      if (decision && !push_ok) begin
        ovfl_q <= 1'b1;
      end
      if (bus.MATCHR && bus.NO_MATCH) begin
        proto_q <= 1'b1;
      end
      out_valid <= head_avail;
      out_match <= head_avail ? head_entry[EVTNUM_W] : 1'b0;
      out_num   <= head_avail ? head_entry[EVTNUM_W-1:0] : '0;
    end
  end

  assign bus.EVT_VALID = out_valid;
  assign bus.EVT_MATCH = out_match;
  assign bus.EVT_NUM   = out_num;
  assign bus.DEPTH     = depth_q;
  assign bus.FULL      = full_q;
  assign bus.OVFL      = ovfl_q;
  assign bus.PROTO_ERR = proto_q;
endmodule

// File: tb/tb_l1a_evt_queue.sv
// tb/tb_l1a_evt_queue.sv - queue-model bench for l1a_evt_queue
module tb_l1a_evt_queue;
  localparam int DEPTH = 8;
  localparam int CMOD  = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l1a_evt_queue_if bus ();

  l1a_evt_queue dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    bit          m;
    int unsigned num;
  } ent_t;

  ent_t        mq[$];
  int unsigned mcnt = 0;
  bit          mvalid = 0, mmatch = 0, movfl = 0, mproto = 0, started = 0;
  int unsigned mnum = 0;
  bit          d_m, popf_m;
  ent_t        e_m;
  int          n_pass = 0, n_total = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // reference: an entry becomes visible on the edge after the one that stored it
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mcnt = 0; movfl = 0; mproto = 0; mvalid = 0; mmatch = 0; mnum = 0;
      started = 1;
    end else if (started) begin
      d_m    = bus.MATCHR | bus.NO_MATCH;
      popf_m = bus.POP && mvalid;
      if (popf_m) void'(mq.pop_front());
      mvalid = mq.size() > 0;
      if (mvalid) begin
        mmatch = mq[0].m;
        mnum   = mq[0].num;
      end else begin
        mmatch = 0;
        mnum   = 0;
      end
      if (d_m) begin
        e_m.m   = bus.MATCHR;
        e_m.num = bus.EVTNUM_RST ? 0 : mcnt;
        if (mq.size() < DEPTH) mq.push_back(e_m);
        else movfl = 1;
        mcnt = (e_m.num + 1) % CMOD;
      end else if (bus.EVTNUM_RST) begin
        mcnt = 0;
      end
      if (bus.MATCHR && bus.NO_MATCH) mproto = 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("valid", bus.EVT_VALID, mvalid);
      chk("depth", bus.DEPTH, mq.size());
      chk("full", bus.FULL, mq.size() == DEPTH);
      chk("ovfl", bus.OVFL, movfl);
      chk("proto", bus.PROTO_ERR, mproto);
      if (mvalid) begin
        chk("match", bus.EVT_MATCH, mmatch);
        chk("num", bus.EVT_NUM, mnum);
      end
    end
  end

  task automatic cyc(bit m, bit n, bit er, bit p);
    bus.MATCHR = m; bus.NO_MATCH = n; bus.EVTNUM_RST = er; bus.POP = p;
    @(negedge clk);
    bus.MATCHR = 0; bus.NO_MATCH = 0; bus.EVTNUM_RST = 0; bus.POP = 0;
  endtask

  task automatic do_rst();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic drain(string nm);
    for (int i = 0; i < 40 && (bus.EVT_VALID || bus.DEPTH != 0); i++) cyc(0, 0, 0, 1);
    chk(nm, bus.DEPTH, 0);
  endtask

  initial begin
    bus.MATCHR = 0; bus.NO_MATCH = 0; bus.EVTNUM_RST = 0; bus.POP = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_depth", bus.DEPTH, 0);
    chk("rst_valid", bus.EVT_VALID, 0);

    // three decisions then pop them in order
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(1, 0, 0, 0);
    chk("s1_depth", bus.DEPTH, 3);
    chk("s1_valid", bus.EVT_VALID, 1);
    chk("s1_m0", bus.EVT_MATCH, 1);
    chk("s1_n0", bus.EVT_NUM, 0);
    cyc(0, 0, 0, 1);
    chk("s1_m1", bus.EVT_MATCH, 0);
    chk("s1_n1", bus.EVT_NUM, 1);
    cyc(0, 0, 0, 1);
    chk("s1_m2", bus.EVT_MATCH, 1);
    chk("s1_n2", bus.EVT_NUM, 2);
    cyc(0, 0, 0, 1);
    chk("s1_empty", bus.EVT_VALID, 0);

    // full queue with simultaneous push and pop
    do_rst();
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);
    chk("s3_full", bus.FULL, 1);
    chk("s3_depth8", bus.DEPTH, 8);
    cyc(1, 0, 0, 1);
    chk("s3_depth_pp", bus.DEPTH, 8);
    chk("s3_ovfl", bus.OVFL, 0);
    for (int i = 0; i < 8; i++) begin
      chk("s3_order", bus.EVT_NUM, i + 1);
      cyc(0, 0, 0, 1);
    end
    chk("s3_done", bus.EVT_VALID, 0);

    // overflow consumes an event number
    do_rst();
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("s2_ovfl", bus.OVFL, 1);
    chk("s2_depth", bus.DEPTH, 8);
    drain("s2_drain");
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("s2_num9", bus.EVT_NUM, 9);

    // reset overrides a push and pop with entries queued and stickies set
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);
    chk("s6_depth3", bus.DEPTH, 3);
    chk("s6_proto", bus.PROTO_ERR, 1);
    rst = 1; bus.MATCHR = 1; bus.POP = 1;
    @(negedge clk);
    rst = 0; bus.MATCHR = 0; bus.POP = 0;
    chk("s6_depth0", bus.DEPTH, 0);
    chk("s6_valid0", bus.EVT_VALID, 0);
    chk("s6_ovfl0", bus.OVFL, 0);
    chk("s6_proto0", bus.PROTO_ERR, 0);
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("s6_num0", bus.EVT_NUM, 0);

    // simultaneous MATCHR and NO_MATCH
    do_rst();
    cyc(1, 1, 0, 0); cyc(0, 0, 0, 0);
    chk("s5_depth", bus.DEPTH, 1);
    chk("s5_match", bus.EVT_MATCH, 1);
    chk("s5_proto", bus.PROTO_ERR, 1);
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 1);
    chk("s5_next", bus.EVT_NUM, 1);
    drain("s5_drain");

    // counter wrap and resync
    do_rst();
    for (int i = 0; i < 4095; i++) cyc(0, 1, 0, 1);
    drain("s4_drain");
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("s4_n4095", bus.EVT_NUM, 4095);
    cyc(0, 0, 0, 1);
    chk("s4_wrap", bus.EVT_NUM, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 1, 0); cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("s4_rs0", bus.EVT_NUM, 0);
    cyc(0, 0, 0, 1);
    chk("s4_rs1", bus.EVT_NUM, 1);
    drain("s4_drain2");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 0));
      rst = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
